// File: rtl/ryl19_pkg.sv
// ryl19_pkg: shared constants and saturating increment for the ryl19 wrap monitor
package ryl19_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ryl19_sync_fifo.sv
// ryl19_sync_fifo: registered first-word-fall-through FIFO with exact occupancy level
module ryl19_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;
  assign full  = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign dout  = head_q;
  assign level = level_q;
  // accept pop only when non-empty, push when space or a same-cycle pop frees it; head register holds its value when drained
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d    = do_push ? AW'(wr_q + 1'b1) : wr_q;
    rd_d    = do_pop ? AW'(rd_q + 1'b1) : rd_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    head_d  = (do_pop && level_q > LW'(1)) ? mem_q[AW'(rd_q + 1'b1)] :
              (do_push && level_q == LW'(do_pop)) ? din : head_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end
endmodule

// File: rtl/ryl19_wrap_monitor.sv
// ryl19_wrap_monitor: counts counter wraps and queues the cycle period between consecutive wraps
module ryl19_wrap_monitor
  import ryl19_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   done_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       out_period,
  output logic [CNT_W-1:0]       wrap_count,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  localparam logic [31:0] MAX = 32'((64'd1 << CNT_W) - 64'd1);
  logic [CNT_W-1:0] gap_q, gap_d, wrap_count_q, wrap_count_d, period;
  logic             armed_q, armed_d, overflow_q, overflow_d;
  logic             wrap, push, full, empty;
  // the first wrap after enable only arms; later wraps push gap+1, dropping on a full FIFO unless a pop makes room
  always_comb begin
    wrap         = en & done_i;
    period       = CNT_W'(sat_inc(32'(gap_q), MAX));
    push         = wrap & armed_q;
    gap_d        = (!en || wrap) ? '0 : period;
    armed_d      = en & (wrap | armed_q);
    wrap_count_d = wrap ? CNT_W'(sat_inc(32'(wrap_count_q), MAX)) : wrap_count_q;
    overflow_d   = overflow_q | (push & full & ~out_ready);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q        <= '0;
      armed_q      <= 1'b0;
      wrap_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      gap_q        <= gap_d;
      armed_q      <= armed_d;
      wrap_count_q <= wrap_count_d;
      overflow_q   <= overflow_d;
    end
  end
  ryl19_sync_fifo #(.WIDTH(CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (period),
    .pop   (out_ready),
    .dout  (out_period),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  assign out_valid  = ~empty;
  assign wrap_count = wrap_count_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_ryl19_wrap_monitor.sv
// tb_ryl19_wrap_monitor: directed vectors with hand-computed expectations for the wrap monitor
module tb_ryl19_wrap_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        done_i = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_period;
  logic [15:0] wrap_count;
  logic [2:0]  fifo_level;
  logic        overflow;
  int          errs = 0;
  int          checks = 0;

  ryl19_wrap_monitor #(.CNT_W(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .done_i     (done_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_period (out_period),
    .wrap_count (wrap_count),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic d, input logic r);
    done_i    = d;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_period"}, 32'(out_period), 0);
    chk({tag, "_wraps"}, 32'(wrap_count), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_reset("rst0");

    // limit 3: pulse every 4 cycles, first only arms
    en = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      cyc(1'b1, 1'b1);
      chk("t1_wraps", 32'(wrap_count), 32'(p));
      chk("t1_valid", 32'(out_valid), (p > 1) ? 1 : 0);
      if (p > 1) chk("t1_period", 32'(out_period), 4);
      repeat (3) cyc(1'b0, 1'b1);
    end
    chk("t1_drained", 32'(out_valid), 0);

    // done held high: arm then five back-to-back wraps of period 1
    do_reset();
    cyc(1'b1, 1'b1);
    chk("t2_arm", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1);
      chk("t2_valid", 32'(out_valid), 1);
      chk("t2_period", 32'(out_period), 1);
      chk("t2_level", 32'(fifo_level), 1);
    end
    cyc(1'b0, 1'b1);
    chk("t2_wraps", 32'(wrap_count), 6);
    chk("t2_empty", 32'(fifo_level), 0);

    // fill to full and overflow with no consumer
    do_reset();
    for (int p = 1; p <= 6; p++) begin
      cyc(1'b1, 1'b0);
      chk("t3_level", 32'(fifo_level), (p - 1 > 4) ? 4 : 32'(p - 1));
      chk("t3_ovf", 32'(overflow), (p == 6) ? 1 : 0);
      repeat (2) cyc(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t3_dvalid", 32'(out_valid), 1);
      chk("t3_dperiod", 32'(out_period), 3);
      cyc(1'b0, 1'b1);
    end
    chk("t3_done_valid", 32'(out_valid), 0);
    chk("t3_done_level", 32'(fifo_level), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // full FIFO with pop and push in the same cycle
    do_reset();
    cyc(1'b1, 1'b0);
    for (int g = 1; g <= 4; g++) begin
      repeat (g) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
    chk("t4_full", 32'(fifo_level), 4);
    chk("t4_head", 32'(out_period), 2);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    chk("t4_level", 32'(fifo_level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head_adv", 32'(out_period), 3);
    cyc(1'b0, 1'b1);
    chk("t4_d1", 32'(out_period), 4);
    cyc(1'b0, 1'b1);
    chk("t4_d2", 32'(out_period), 5);
    cyc(1'b0, 1'b1);
    chk("t4_d3", 32'(out_period), 2);
    cyc(1'b0, 1'b1);
    chk("t4_empty", 32'(out_valid), 0);

    // gap saturation, then en low mid-gap disarms and ignores done
    do_reset();
    cyc(1'b1, 1'b1);
    repeat (70000) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("t5_sat_valid", 32'(out_valid), 1);
    chk("t5_sat_period", 32'(out_period), 65535);
    chk("t5_wraps", 32'(wrap_count), 2);
    repeat (3) cyc(1'b0, 1'b1);
    en = 1'b0;
    cyc(1'b1, 1'b1);
    chk("t5_en0_wraps", 32'(wrap_count), 2);
    en = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("t5_rearm_valid", 32'(out_valid), 0);
    chk("t5_rearm_wraps", 32'(wrap_count), 3);
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("t5_after_valid", 32'(out_valid), 1);
    chk("t5_after_period", 32'(out_period), 3);

    // reset mid-measurement with entries queued
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("t6_level", 32'(fifo_level), 2);
    chk("t6_head", 32'(out_period), 2);
    repeat (2) cyc(1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    chk_reset("t6_rst");
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("t6_arm_valid", 32'(out_valid), 0);
    chk("t6_arm_wraps", 32'(wrap_count), 1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("t6_period", 32'(out_period), 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ryl19_wrap_monitor.md
Name: ryl19_wrap_monitor

Overview:
- Downstream stage of the ryl19 limit counter; consumes its one-cycle `done` wrap strobe.
- Counts wrap events and measures the period between consecutive wraps in clock cycles.
- Queues measured periods in a small FIFO that drains over a valid/ready interface to the host-side readout logic.
- Gives the tile a self-check: a limit of L must yield a period of L+1.

Parameters:
- CNT_W, 16: width of the period measurement, the wrap counter and the period FIFO entries.
- DEPTH, 4: number of period FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  monitor enable; mirrors the counter's enable.
- done_i  in  1  wrap strobe from the counter; each high cycle is one wrap event.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry when out_valid & out_ready.
- out_period  out  CNT_W  head FIFO entry, in cycles.
- wrap_count  out  CNT_W  saturating count of wrap events.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- overflow  out  1  sticky: a period was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - out_valid=0, out_period=0, wrap_count=0, fifo_level=0, overflow=0.
  - Internal gap counter = 0, armed = 0.
  - Reset wins over every other input in the same cycle, including mid-measurement and mid-drain; FIFO contents are discarded.
- Gap counter:
  - Increments every en=1 cycle without a wrap event.
  - Saturates at 2^CNT_W-1.
  - Set to 0 on a wrap event.
- Wrap event = en & done_i.
  - wrap_count increments, saturating at 2^CNT_W-1.
  - If armed=0: set armed=1; nothing is pushed.
  - If armed=1: push period = gap+1, saturating to 2^CNT_W-1 when gap is already saturated.
  - Consecutive done cycles give period 1.
- en=0:
  - gap←0, armed←0; done_i is ignored.
  - FIFO contents, wrap_count and overflow are held; popping still works.
- FIFO:
  - Registered; first-word fall-through.
  - A push into an empty FIFO shows out_valid=1 with the value on out_period on the cycle after the wrap event (latency 1).
  - Pop occurs when out_valid & out_ready. A pop on an empty FIFO is a no-op.
  - Push while full without a same-cycle pop: the entry is dropped and overflow←1.
  - Push while full with a same-cycle pop: both are accepted; level stays DEPTH, overflow is not set.
  - Simultaneous push and pop at any other level: level unchanged.
  - out_period holds its last value while out_valid=0 and carries no meaning then.
- overflow clears only on rst.
- fifo_level is exact at all times, range 0..DEPTH.

Decomposition:
- Package ryl19_pkg holds:
  - default CNT_W and DEPTH constants;
  - the saturating-increment function shared by the gap counter and wrap_count.
- Sub-module ryl19_sync_fifo: parameterised WIDTH/DEPTH, synchronous active-high reset, push/pop/full/empty/level.
- The top holds the gap counter, armed flag, wrap counter and overflow logic.

Test Plan:
- Reset then en=1, done_i pulse every 4 cycles (counter limit 3), out_ready=1 → first pulse only arms; every later entry out_period=4; wrap_count=N after N pulses.
- done_i held high for 5 cycles after arming, out_ready=1 → five entries of 1, wrap_count=6 (arming pulse included).
- out_ready=0, done_i every 3 cycles for 6 pulses, DEPTH=4 → fifo_level caps at 4 with entries 3,3,3,3; overflow=1 after pulse 6; then out_ready=1 drains 3,3,3,3 and out_valid→0.
- FIFO full, out_ready=1 on the same cycle as a wrap event → level stays 4, overflow stays 0, head advances.
- Arm, then 70000 cycles with no done_i (CNT_W=16), then a pulse → entry 65535; pulse en low mid-gap → next pulse re-arms and pushes nothing.
- Assert rst with 2 entries queued and a gap in progress → all outputs at reset values the next cycle; the first post-reset pulse only arms.
